// File: rtl/cw305_prog_bridge_pkg.sv
// Shared constants and FSM encoding for the CW305 USB programming bridge.
// Status bit positions match the register block's status byte.
package cw305_prog_bridge_pkg;

  localparam int unsigned STAT_PROG_EN        = 0;
  localparam int unsigned STAT_INSTR_VALID    = 1;
  localparam int unsigned STAT_NEW_ADDR_VALID = 2;

  localparam logic [3:0] OBI_BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_ACK  = 3'd1,
    ST_WR_REQ    = 3'd2,
    ST_WR_RESP   = 3'd3,
    ST_INSTR_ACK = 3'd4
  } state_e;

endpackage

// File: rtl/cw305_bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module cw305_bit_sync #(
  parameter int unsigned pSYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [pSYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[pSYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[pSYNC_STAGES-1];

endmodule

// File: rtl/cw305_prog_bridge.sv
// Consumes USB-written address/instruction registers and writes each instruction
// into X-HEEP memory over an OBI master port, returning level clear strobes.
module cw305_prog_bridge
  import cw305_prog_bridge_pkg::*;
#(
  parameter int unsigned pINSTR_WIDTH = 32,
  parameter int unsigned pSYNC_STAGES = 2,
  parameter int unsigned pCNT_WIDTH   = 16
) (
  input  logic                    crypto_clk,
  input  logic                    reset_i,
  input  logic [7:0]              I_status,
  input  logic [pINSTR_WIDTH-1:0] I_instruction,
  input  logic [pINSTR_WIDTH-1:0] I_address,
  output logic                    O_reset_new_addr_valid,
  output logic                    O_reset_instr_valid,
  output logic                    O_obi_req,
  input  logic                    I_obi_gnt,
  output logic [pINSTR_WIDTH-1:0] O_obi_addr,
  output logic                    O_obi_we,
  output logic [3:0]              O_obi_be,
  output logic [pINSTR_WIDTH-1:0] O_obi_wdata,
  input  logic                    I_obi_rvalid,
  output logic                    O_busy,
  output logic [pCNT_WIDTH-1:0]   O_word_count
);

  logic w_s_en, w_s_iv, w_s_av;
  logic w_unused;

  state_e                  r_state, w_state_n;
  logic [pINSTR_WIDTH-1:0] r_ptr, w_ptr_n;
  logic [pCNT_WIDTH-1:0]   r_cnt, w_cnt_n;
  logic                    r_req, w_req_n;
  logic                    r_we, w_we_n;
  logic [3:0]              r_be, w_be_n;
  logic [pINSTR_WIDTH-1:0] r_addr, w_addr_n;
  logic [pINSTR_WIDTH-1:0] r_wdata, w_wdata_n;
  logic                    r_clr_av, w_clr_av_n;
  logic                    r_clr_iv, w_clr_iv_n;
  logic                    r_busy, w_busy_n;

  assign w_unused = ^{I_status[7:3], I_address[1:0]};

  cw305_bit_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync_en (
    .i_clk(crypto_clk), .i_rst(reset_i), .i_d(I_status[STAT_PROG_EN]), .o_q(w_s_en));
  cw305_bit_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync_iv (
    .i_clk(crypto_clk), .i_rst(reset_i), .i_d(I_status[STAT_INSTR_VALID]), .o_q(w_s_iv));
  cw305_bit_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_sync_av (
    .i_clk(crypto_clk), .i_rst(reset_i), .i_d(I_status[STAT_NEW_ADDR_VALID]), .o_q(w_s_av));

  // State and every output are flops; next values come from the block below.
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_clr_av <= 1'b1;
      r_clr_iv <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_ptr    <= w_ptr_n;
      r_cnt    <= w_cnt_n;
      r_req    <= w_req_n;
      r_we     <= w_we_n;
      r_be     <= w_be_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_clr_av <= w_clr_av_n;
      r_clr_iv <= w_clr_iv_n;
      r_busy   <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_cnt_n    = r_cnt;
    w_req_n    = r_req;
    w_we_n     = r_we;
    w_be_n     = r_be;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_clr_av_n = r_clr_av;
    w_clr_iv_n = r_clr_iv;

    case (r_state)
      ST_IDLE: begin
        if (w_s_en && w_s_av) begin
          w_state_n  = ST_ADDR_ACK;
          w_ptr_n    = {I_address[pINSTR_WIDTH-1:2], 2'b00};
          w_cnt_n    = '0;
          w_clr_av_n = 1'b0;
        end else if (w_s_en && w_s_iv) begin
          w_state_n = ST_WR_REQ;
          w_addr_n  = r_ptr;
          w_wdata_n = I_instruction;
          w_req_n   = 1'b1;
          w_we_n    = 1'b1;
          w_be_n    = OBI_BE_ALL;
        end
      end
      ST_ADDR_ACK: begin
        if (!w_s_av) begin
          w_clr_av_n = 1'b1;
          w_state_n  = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (I_obi_gnt) begin
          w_req_n = 1'b0;
          w_we_n  = 1'b0;
          w_be_n  = '0;
          // A same-cycle response skips the wait state.
          if (I_obi_rvalid) begin
            w_ptr_n    = r_ptr + pINSTR_WIDTH'(4);
            w_cnt_n    = r_cnt + pCNT_WIDTH'(1);
            w_clr_iv_n = 1'b0;
            w_state_n  = ST_INSTR_ACK;
          end else begin
            w_state_n = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        if (I_obi_rvalid) begin
          w_ptr_n    = r_ptr + pINSTR_WIDTH'(4);
          w_cnt_n    = r_cnt + pCNT_WIDTH'(1);
          w_clr_iv_n = 1'b0;
          w_state_n  = ST_INSTR_ACK;
        end
      end
      ST_INSTR_ACK: begin
        if (!w_s_iv) begin
          w_clr_iv_n = 1'b1;
          w_state_n  = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    w_busy_n = (w_state_n != ST_IDLE);
  end

  assign O_reset_new_addr_valid = r_clr_av;
  assign O_reset_instr_valid    = r_clr_iv;
  assign O_obi_req              = r_req;
  assign O_obi_we               = r_we;
  assign O_obi_be               = r_be;
  assign O_obi_addr             = r_addr;
  assign O_obi_wdata            = r_wdata;
  assign O_busy                 = r_busy;
  assign O_word_count           = r_cnt;

endmodule

// File: tb/tb_cw305_prog_bridge.sv
// Directed self-checking bench for cw305_prog_bridge: host register model and
// an OBI slave with programmable grant/response delays.
module tb_cw305_prog_bridge;

  logic        crypto_clk;
  logic        reset_i;
  logic [7:0]  I_status;
  logic [31:0] I_instruction;
  logic [31:0] I_address;
  logic        O_reset_new_addr_valid;
  logic        O_reset_instr_valid;
  logic        O_obi_req;
  logic        I_obi_gnt;
  logic [31:0] O_obi_addr;
  logic        O_obi_we;
  logic [3:0]  O_obi_be;
  logic [31:0] O_obi_wdata;
  logic        I_obi_rvalid;
  logic        O_busy;
  logic [15:0] O_word_count;

  int n_vec = 0;
  int n_err = 0;
  int n_req_rise = 0;
  logic r_req_d = 1'b0;

  cw305_prog_bridge #(.pINSTR_WIDTH(32), .pSYNC_STAGES(2), .pCNT_WIDTH(16)) dut (
    .crypto_clk(crypto_clk), .reset_i(reset_i), .I_status(I_status),
    .I_instruction(I_instruction), .I_address(I_address),
    .O_reset_new_addr_valid(O_reset_new_addr_valid),
    .O_reset_instr_valid(O_reset_instr_valid),
    .O_obi_req(O_obi_req), .I_obi_gnt(I_obi_gnt), .O_obi_addr(O_obi_addr),
    .O_obi_we(O_obi_we), .O_obi_be(O_obi_be), .O_obi_wdata(O_obi_wdata),
    .I_obi_rvalid(I_obi_rvalid), .O_busy(O_busy), .O_word_count(O_word_count));

  initial crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  // Counts distinct OBI requests issued.
  always @(negedge crypto_clk) begin
    if (O_obi_req && !r_req_d) n_req_rise <= n_req_rise + 1;
    r_req_d <= O_obi_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // OBI slave for one write; returns the sampled request and handshake info.
  task automatic obi_write(input int gnt_dly, input int rv_dly, input bit drop_en,
                           output logic [31:0] a, output logic [31:0] d,
                           output logic [3:0] be, output logic we,
                           output bit stable, output int lat, output bit ok);
    ok = 0; stable = 1; lat = 0; a = '0; d = '0; be = '0; we = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge crypto_clk);
      lat++;
      if (O_obi_req) ok = 1;
    end
    if (!ok) return;
    a = O_obi_addr; d = O_obi_wdata; be = O_obi_be; we = O_obi_we;
    if (drop_en) I_status[0] = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge crypto_clk);
      if (!O_obi_req || O_obi_addr !== a || O_obi_wdata !== d) stable = 0;
    end
    I_obi_gnt = 1'b1;
    I_obi_rvalid = (rv_dly == 0);
    @(negedge crypto_clk);
    I_obi_gnt = 1'b0;
    I_obi_rvalid = 1'b0;
    if (O_obi_req) stable = 0;
    if (rv_dly > 0) begin
      repeat (rv_dly - 1) @(negedge crypto_clk);
      I_obi_rvalid = 1'b1;
      @(negedge crypto_clk);
      I_obi_rvalid = 1'b0;
    end
  endtask

  // Host side of a clear handshake: wait for strobe low, keep flag set a while, clear it.
  task automatic ack_flag(input int bitn, output bit held, output bit ok);
    logic s;
    ok = 0; held = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge crypto_clk);
      s = (bitn == 1) ? O_reset_instr_valid : O_reset_new_addr_valid;
      if (s === 1'b0) ok = 1;
    end
    if (!ok) return;
    repeat (4) begin
      @(negedge crypto_clk);
      s = (bitn == 1) ? O_reset_instr_valid : O_reset_new_addr_valid;
      if (s !== 1'b0) held = 0;
    end
    I_status[bitn] = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge crypto_clk);
      s = (bitn == 1) ? O_reset_instr_valid : O_reset_new_addr_valid;
      if (s === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({O_reset_new_addr_valid, O_reset_instr_valid} !== 2'b11) begin
      n_err++; $display("FAIL reset_strobes: got %b want 11", {O_reset_new_addr_valid, O_reset_instr_valid});
    end
    n_vec++;
    if ({O_obi_req, O_obi_we, O_obi_be} !== 6'b0) begin
      n_err++; $display("FAIL reset_obi_ctrl: got %b want 000000", {O_obi_req, O_obi_we, O_obi_be});
    end
    n_vec++;
    if ({O_obi_addr, O_obi_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_obi_data: got %h/%h want 0/0", O_obi_addr, O_obi_wdata);
    end
    n_vec++;
    if ({O_busy, O_word_count} !== 17'h0) begin
      n_err++; $display("FAIL reset_busy_cnt: got %b/%0d want 0/0", O_busy, O_word_count);
    end
  endtask

  task automatic test_addr_load();
    bit held, ok;
    int base;
    base = n_req_rise;
    I_address = 32'h0000_1003;
    I_status = 8'h05;
    ack_flag(2, held, ok);
    n_vec++;
    if (!(ok && held)) begin
      n_err++; $display("FAIL addr_ack_strobe: got ok=%0d held=%0d want 1/1", ok, held);
    end
    n_vec++;
    if (n_req_rise !== base || O_busy !== 1'b0) begin
      n_err++; $display("FAIL addr_no_req: got reqs=%0d busy=%b want 0/0", n_req_rise - base, O_busy);
    end
  endtask

  task automatic test_single_write();
    logic [31:0] a, d; logic [3:0] be; logic we; bit st, ok, held; int lat, base;
    base = n_req_rise;
    I_instruction = 32'hDEAD_BEEF;
    I_status = 8'h03;
    obi_write(3, 2, 0, a, d, be, we, st, lat, ok);
    n_vec++;
    if (!ok || lat !== 3) begin
      n_err++; $display("FAIL single_latency: got ok=%0d lat=%0d want 1/3", ok, lat);
    end
    n_vec++;
    if (a !== 32'h0000_1000 || d !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_addr_data: got %h/%h want 00001000/deadbeef", a, d);
    end
    n_vec++;
    if ({we, be} !== 5'h1F || !st) begin
      n_err++; $display("FAIL single_we_be_stable: got we=%b be=%h stable=%0d want 1/f/1", we, be, st);
    end
    ack_flag(1, held, ok);
    n_vec++;
    if (!(ok && held)) begin
      n_err++; $display("FAIL single_instr_ack: got ok=%0d held=%0d want 1/1", ok, held);
    end
    n_vec++;
    if (O_word_count !== 16'd1 || n_req_rise - base !== 1) begin
      n_err++; $display("FAIL single_count: got cnt=%0d reqs=%0d want 1/1", O_word_count, n_req_rise - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d; logic [3:0] be; logic we; bit st, ok, held; int lat;
    I_address = 32'h0000_1000;
    I_status = 8'h05;
    ack_flag(2, held, ok);
    for (int i = 0; i < 4; i++) begin
      I_instruction = 32'h1111_0000 + 32'(i);
      I_status = 8'h03;
      obi_write(i, i % 3, 0, a, d, be, we, st, lat, ok);
      n_vec++;
      if (!ok || a !== 32'h0000_1000 + 32'(4 * i) || d !== 32'h1111_0000 + 32'(i) || !st) begin
        n_err++; $display("FAIL burst_write%0d: got addr=%h data=%h stable=%0d want %h/%h/1",
                          i, a, d, st, 32'h0000_1000 + 32'(4 * i), 32'h1111_0000 + 32'(i));
      end
      ack_flag(1, held, ok);
    end
    n_vec++;
    if (O_word_count !== 16'd4) begin
      n_err++; $display("FAIL burst_count: got %0d want 4", O_word_count);
    end
    I_address = 32'h0000_2000;
    I_status = 8'h05;
    ack_flag(2, held, ok);
    n_vec++;
    if (!ok || O_word_count !== 16'd0) begin
      n_err++; $display("FAIL reload_count: got ok=%0d cnt=%0d want 1/0", ok, O_word_count);
    end
    I_instruction = 32'h2222_0000;
    I_status = 8'h03;
    obi_write(1, 1, 0, a, d, be, we, st, lat, ok);
    ack_flag(1, held, ok);
    n_vec++;
    if (a !== 32'h0000_2000 || O_word_count !== 16'd1) begin
      n_err++; $display("FAIL reload_write: got addr=%h cnt=%0d want 00002000/1", a, O_word_count);
    end
  endtask

  task automatic test_both_flags();
    logic [31:0] a, d; logic [3:0] be; logic we; bit st, ok, held; int lat;
    I_address = 32'h0000_3000;
    I_instruction = 32'hCAFE_F00D;
    I_status = 8'h07;
    ack_flag(2, held, ok);
    n_vec++;
    if (!ok || O_obi_req !== 1'b0 || O_reset_instr_valid !== 1'b1) begin
      n_err++; $display("FAIL both_addr_first: got ok=%0d req=%b clr_iv=%b want 1/0/1", ok, O_obi_req, O_reset_instr_valid);
    end
    obi_write(0, 1, 0, a, d, be, we, st, lat, ok);
    ack_flag(1, held, ok);
    n_vec++;
    if (a !== 32'h0000_3000 || d !== 32'hCAFE_F00D || O_word_count !== 16'd1) begin
      n_err++; $display("FAIL both_write: got %h/%h cnt=%0d want 00003000/cafef00d/1", a, d, O_word_count);
    end
  endtask

  task automatic test_edge_cases();
    logic [31:0] a, d; logic [3:0] be; logic we; bit st, ok, held; int lat, base;
    base = n_req_rise;
    I_status = 8'h02;
    repeat (10) @(negedge crypto_clk);
    n_vec++;
    if (n_req_rise !== base || {O_reset_new_addr_valid, O_reset_instr_valid, O_busy} !== 3'b110) begin
      n_err++; $display("FAIL en_low_idle: got reqs=%0d strobes/busy=%b want 0/110",
                        n_req_rise - base, {O_reset_new_addr_valid, O_reset_instr_valid, O_busy});
    end
    I_status = 8'h00;
    repeat (3) @(negedge crypto_clk);
    I_instruction = 32'hA5A5_5A5A;
    I_status = 8'h03;
    obi_write(3, 1, 1, a, d, be, we, st, lat, ok);
    ack_flag(1, held, ok);
    n_vec++;
    if (!ok || a !== 32'h0000_3004 || O_word_count !== 16'd2) begin
      n_err++; $display("FAIL en_drop_completes: got ok=%0d addr=%h cnt=%0d want 1/00003004/2", ok, a, O_word_count);
    end
    I_address = 32'hFFFF_FFFF;
    I_status = 8'h05;
    ack_flag(2, held, ok);
    I_instruction = 32'h0000_0001;
    I_status = 8'h03;
    obi_write(0, 0, 0, a, d, be, we, st, lat, ok);
    ack_flag(1, held, ok);
    n_vec++;
    if (a !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_first: got %h want fffffffc", a);
    end
    I_instruction = 32'h0000_0002;
    I_status = 8'h03;
    obi_write(2, 0, 0, a, d, be, we, st, lat, ok);
    ack_flag(1, held, ok);
    n_vec++;
    if (a !== 32'h0000_0000 || O_word_count !== 16'd2) begin
      n_err++; $display("FAIL wrap_second: got addr=%h cnt=%0d want 00000000/2", a, O_word_count);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a, d; logic [3:0] be; logic we; bit st, ok, held; int lat;
    I_instruction = 32'h0BAD_F00D;
    I_status = 8'h03;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge crypto_clk);
      if (O_obi_req) ok = 1;
    end
    I_obi_gnt = 1'b1;
    @(negedge crypto_clk);
    I_obi_gnt = 1'b0;
    n_vec++;
    if (!ok || O_busy !== 1'b1 || O_obi_req !== 1'b0) begin
      n_err++; $display("FAIL mid_in_resp: got ok=%0d busy=%b req=%b want 1/1/0", ok, O_busy, O_obi_req);
    end
    #2 reset_i = 1'b1;
    #1;
    n_vec++;
    if ({O_reset_new_addr_valid, O_reset_instr_valid, O_obi_req, O_obi_we, O_obi_be, O_busy} !== 9'b110000000
        || O_obi_addr !== 32'h0 || O_obi_wdata !== 32'h0 || O_word_count !== 16'd0) begin
      n_err++; $display("FAIL mid_async_reset: got ctrl=%b addr=%h data=%h cnt=%0d want 110000000/0/0/0",
                        {O_reset_new_addr_valid, O_reset_instr_valid, O_obi_req, O_obi_we, O_obi_be, O_busy},
                        O_obi_addr, O_obi_wdata, O_word_count);
    end
    I_status = 8'h00;
    @(negedge crypto_clk);
    reset_i = 1'b0;
    repeat (2) @(negedge crypto_clk);
    n_vec++;
    if (O_busy !== 1'b0 || O_obi_req !== 1'b0) begin
      n_err++; $display("FAIL mid_idle_after: got busy=%b req=%b want 0/0", O_busy, O_obi_req);
    end
    I_instruction = 32'h1234_5678;
    I_status = 8'h03;
    obi_write(1, 1, 0, a, d, be, we, st, lat, ok);
    ack_flag(1, held, ok);
    n_vec++;
    if (a !== 32'h0 || d !== 32'h1234_5678 || O_word_count !== 16'd1) begin
      n_err++; $display("FAIL mid_ptr_cleared: got %h/%h cnt=%0d want 00000000/12345678/1", a, d, O_word_count);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    I_status = 8'h07;
    I_instruction = 32'h0;
    I_address = 32'h0;
    I_obi_gnt = 1'b0;
    I_obi_rvalid = 1'b0;
    repeat (3) @(negedge crypto_clk);
    test_reset();
    I_status = 8'h00;
    @(negedge crypto_clk);
    reset_i = 1'b0;
    repeat (2) @(negedge crypto_clk);
    test_addr_load();
    test_single_write();
    test_back_to_back();
    test_both_flags();
    test_edge_cases();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
